stack_op_controller: RTL and testbench
======================================

Name: stack_op_controller

Overview:
Sequences the 8-bit stack pointer and data-memory port for PUSH, POP, CALL, RET and LDSP. Sits between the decode/execute stage and the stack-pointer register. Drives the SP inc/dec/load strobes and the memory strobes. Tracks stack depth so overflow and underflow are rejected before the SP moves.

Parameters:
DATA_W, 8, width of data, PC, flags and SP.
SP_TOP, 8'hFF, empty-stack SP value.
MAX_DEPTH, 255, maximum number of stacked words.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
req_valid  in  1  request present.
req_ready  out  1  controller can accept; high only in IDLE.
req_op  in  3  0 NOP, 1 PUSH, 2 POP, 3 CALL, 4 RET, 5 LDSP, 6-7 illegal.
req_data  in  DATA_W  PUSH data / LDSP value (R0).
req_pc  in  DATA_W  return address for CALL.
req_flags  in  DATA_W  flags for CALL.
sp_inc  out  1  to SP I_SP.
sp_dec  out  1  to SP D_SP; sp_inc and sp_dec both high = load.
sp_load_val  out  DATA_W  to SP R0_in.
mem_we  out  1  stack write strobe; address is the SP output.
mem_re  out  1  stack read strobe; sync RAM, data valid next cycle.
mem_wdata  out  DATA_W  write data.
mem_rdata  in  DATA_W  read data.
rsp_valid  out  1  one-cycle pulse: POP/RET result valid.
rsp_data  out  DATA_W  POP data or RET flags.
rsp_pc  out  DATA_W  RET return address.
depth  out  DATA_W+1  current stacked word count.
ovf_err  out  1  one-cycle pulse: push-type op rejected.
unf_err  out  1  one-cycle pulse: pop-type op rejected.

Behaviour:
- Reset (async, rst_n=0): state IDLE, depth=0, all strobes, rsp_valid and errors are 0, data regs are 0.
- Reset aborts any operation immediately. A half-done CALL/RET leaves the SP inconsistent; software must issue LDSP SP_TOP afterwards.
- Accept a request when req_valid && req_ready, at edge T. Operands latch at T. Strobes begin in cycle T+1.
- NOP and illegal ops are accepted and produce no action.
- States: IDLE, PUSH, POP_RD, POP_CAP, CALL_PC, CALL_FL, RET_FL, RET_PC, RET_CAP, LDSP.
- PUSH: in T+1, sp_dec=1, mem_we=1, mem_wdata=data (written at SP-1). Then IDLE. depth+1.
- POP: POP_RD (sp_inc=1, mem_re=1), then POP_CAP (latch mem_rdata), then IDLE. rsp_valid=1 in the IDLE cycle. depth-1.
- CALL: CALL_PC pushes the PC, then CALL_FL pushes the flags. Then IDLE. depth+2.
- RET: RET_FL (pop read), RET_PC (pop read, latch flags), RET_CAP (latch PC), then IDLE. rsp_valid=1 with rsp_data=flags and rsp_pc=PC. depth-2.
- LDSP: one cycle with sp_inc=sp_dec=1 and sp_load_val=data. depth := SP_TOP - data.
- Only LDSP may drive sp_inc and sp_dec high together.
- Rejection: PUSH when depth==MAX_DEPTH, or CALL when depth>MAX_DEPTH-2, raises ovf_err. POP when depth==0, or RET when depth<2, raises unf_err.
  - A rejected request is still consumed and the state stays IDLE.
  - The error pulse occurs in T+1 with no strobes and no SP or depth change.
- rsp_data and rsp_pc hold their values until the next response.
- sp_load_val is 0 outside LDSP. mem_wdata is 0 when mem_we=0.

Decomposition:
- Shared package holds: opcode localparams (OP_NOP..OP_LDSP), the state encoding, and SP_TOP.
- No sub-module: the depth counter and FSM live in one module.

Test Plan:
- Reset, then PUSH 8'hA5 -> T+1: sp_dec=1, mem_we=1, mem_wdata=A5. depth=1. req_ready low for one cycle.
- PUSH 11, PUSH 22, POP, POP -> rsp_data 22 then 11, each 3 cycles after accept. depth returns to 0.
- CALL pc=8'h40 flags=8'h05, then RET -> 2 writes (40 then 05). RET reads give rsp_pc=40 and rsp_flags=05 with a single rsp_valid. depth 0→2→0.
- POP at depth 0 and RET at depth 1 -> unf_err pulse, no sp_inc, no mem_re, depth unchanged. LDSP 8'h00 (depth=255) then PUSH -> ovf_err.
- LDSP 8'hF0 -> one cycle sp_inc=sp_dec=1, sp_load_val=F0. depth=15.
- Assert rst_n=0 during CALL_FL -> strobes drop asynchronously. After release: IDLE, depth=0, req_ready=1.

Source files
------------

// File: rtl/stack_op_controller_pkg.sv
// Shared opcodes, FSM state encoding and empty-stack SP value for the stack operation controller.
package stack_op_controller_pkg;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_PUSH = 3'd1;
  localparam logic [2:0] OP_POP  = 3'd2;
  localparam logic [2:0] OP_CALL = 3'd3;
  localparam logic [2:0] OP_RET  = 3'd4;
  localparam logic [2:0] OP_LDSP = 3'd5;

  localparam logic [7:0] SP_TOP = 8'hFF;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_PUSH    = 4'd1,
    ST_POP_RD  = 4'd2,
    ST_POP_CAP = 4'd3,
    ST_CALL_PC = 4'd4,
    ST_CALL_FL = 4'd5,
    ST_RET_FL  = 4'd6,
    ST_RET_PC  = 4'd7,
    ST_RET_CAP = 4'd8,
    ST_LDSP    = 4'd9
  } state_t;

endpackage

// File: rtl/stack_op_if.sv
// Request, SP-strobe, stack-memory and response signals between execute stage and stack controller.
interface stack_op_if #(parameter int DATA_W = 8);
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_op;
  logic [DATA_W-1:0] req_data;
  logic [DATA_W-1:0] req_pc;
  logic [DATA_W-1:0] req_flags;
  logic              sp_inc;
  logic              sp_dec;
  logic [DATA_W-1:0] sp_load_val;
  logic              mem_we;
  logic              mem_re;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic [DATA_W-1:0] rsp_pc;
  logic [DATA_W:0]   depth;
  logic              ovf_err;
  logic              unf_err;

  modport master (
    output req_valid, req_op, req_data, req_pc, req_flags, mem_rdata,
    input  req_ready, sp_inc, sp_dec, sp_load_val, mem_we, mem_re, mem_wdata,
           rsp_valid, rsp_data, rsp_pc, depth, ovf_err, unf_err
  );

  modport slave (
    input  req_valid, req_op, req_data, req_pc, req_flags, mem_rdata,
    output req_ready, sp_inc, sp_dec, sp_load_val, mem_we, mem_re, mem_wdata,
           rsp_valid, rsp_data, rsp_pc, depth, ovf_err, unf_err
  );
endinterface

// File: rtl/stack_op_controller.sv
// Sequences SP strobes and stack-memory accesses for PUSH/POP/CALL/RET/LDSP,
// tracking depth so overflow/underflow is rejected before the SP moves.
//
// state      | meaning
// IDLE       | ready for a request; response/error pulses appear here
// PUSH       | write data at SP-1, decrement SP
// POP_RD     | read at SP, increment SP
// POP_CAP    | capture popped word
// CALL_PC    | push return address
// CALL_FL    | push flags
// RET_FL     | pop-read flags
// RET_PC     | pop-read return address, hold flags
// RET_CAP    | capture return address
// LDSP       | load SP from data (inc+dec together)
module stack_op_controller
  import stack_op_controller_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int MAX_DEPTH = 255
) (
  input  logic     clk,
  input  logic     rst_n,
  stack_op_if.slave bus
);

  localparam int DEPTH_W = DATA_W + 1;

  state_t              state_q, state_d;
  logic [DEPTH_W-1:0]  depth_q, depth_d;
  logic [DATA_W-1:0]   data_q, pc_q, flags_q, ret_fl_q;
  logic [DATA_W-1:0]   rsp_data_q, rsp_pc_q;
  logic                rsp_valid_q, ovf_q, unf_q, ovf_d, unf_d;
  logic                accept;
  logic                push_full, call_full, pop_empty, ret_empty;

  assign accept    = bus.req_valid && (state_q == ST_IDLE);
  assign push_full = (depth_q == DEPTH_W'(MAX_DEPTH));
  assign call_full = (depth_q >  DEPTH_W'(MAX_DEPTH - 2));
  assign pop_empty = (depth_q == '0);
  assign ret_empty = (depth_q <  DEPTH_W'(2));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Rejected requests are consumed in IDLE and only raise the registered error pulse.
  always_comb begin
    state_d = state_q;
    ovf_d   = 1'b0;
    unf_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          case (bus.req_op)
            OP_PUSH: if (push_full) ovf_d = 1'b1; else state_d = ST_PUSH;
            OP_POP:  if (pop_empty) unf_d = 1'b1; else state_d = ST_POP_RD;
            OP_CALL: if (call_full) ovf_d = 1'b1; else state_d = ST_CALL_PC;
            OP_RET:  if (ret_empty) unf_d = 1'b1; else state_d = ST_RET_FL;
            OP_LDSP: state_d = ST_LDSP;
            default: state_d = ST_IDLE;
          endcase
        end
      end
      ST_POP_RD:  state_d = ST_POP_CAP;
      ST_CALL_PC: state_d = ST_CALL_FL;
      ST_RET_FL:  state_d = ST_RET_PC;
      ST_RET_PC:  state_d = ST_RET_CAP;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.sp_inc      = 1'b0;
    bus.sp_dec      = 1'b0;
    bus.sp_load_val = '0;
    bus.mem_we      = 1'b0;
    bus.mem_re      = 1'b0;
    bus.mem_wdata   = '0;
    case (state_q)
      ST_PUSH: begin
        bus.sp_dec    = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_wdata = data_q;
      end
      ST_CALL_PC: begin
        bus.sp_dec    = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_wdata = pc_q;
      end
      ST_CALL_FL: begin
        bus.sp_dec    = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_wdata = flags_q;
      end
      ST_POP_RD, ST_RET_FL, ST_RET_PC: begin
        bus.sp_inc = 1'b1;
        bus.mem_re = 1'b1;
      end
      ST_LDSP: begin
        bus.sp_inc      = 1'b1;
        bus.sp_dec      = 1'b1;
        bus.sp_load_val = data_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    depth_d = depth_q;
    case (state_q)
      ST_PUSH, ST_CALL_PC, ST_CALL_FL:  depth_d = depth_q + 1'b1;
      ST_POP_RD, ST_RET_FL, ST_RET_PC:  depth_d = depth_q - 1'b1;
      ST_LDSP:  depth_d = DEPTH_W'(SP_TOP) - {1'b0, data_q};
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      depth_q     <= '0;
      data_q      <= '0;
      pc_q        <= '0;
      flags_q     <= '0;
      ret_fl_q    <= '0;
      rsp_data_q  <= '0;
      rsp_pc_q    <= '0;
      rsp_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
    end else begin
      depth_q     <= depth_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
      rsp_valid_q <= (state_q == ST_POP_CAP) || (state_q == ST_RET_CAP);
      if (accept) begin
        data_q  <= bus.req_data;
        pc_q    <= bus.req_pc;
        flags_q <= bus.req_flags;
      end
      // RET flags are parked so rsp_data keeps its old value until the response pulse.
      case (state_q)
        ST_POP_CAP: rsp_data_q <= bus.mem_rdata;
        ST_RET_PC:  ret_fl_q   <= bus.mem_rdata;
        ST_RET_CAP: begin
          rsp_data_q <= ret_fl_q;
          rsp_pc_q   <= bus.mem_rdata;
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready = (state_q == ST_IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_pc    = rsp_pc_q;
  assign bus.depth     = depth_q;
  assign bus.ovf_err   = ovf_q;
  assign bus.unf_err   = unf_q;

endmodule

// File: tb/tb_stack_op_controller.sv
// Scoreboard bench for stack_op_controller: stack-level reference model plus SP register and sync RAM environment.
module tb_stack_op_controller;
  import stack_op_controller_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  stack_op_if #(.DATA_W(8)) bus ();
  stack_op_controller #(.DATA_W(8), .MAX_DEPTH(255)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  // Environment: external SP register and synchronous stack RAM.
  logic [7:0] ram [256];
  logic [7:0] sp_env = 8'hFF;
  logic [7:0] rdata_q = 8'h00;
  logic       init_done = 1'b0;
  assign bus.mem_rdata = rdata_q;

  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 256; i++) ram[i] <= 8'(i) ^ 8'h5A;
      init_done <= 1'b1;
    end else begin
      if (bus.sp_inc && bus.sp_dec) sp_env <= bus.sp_load_val;
      else if (bus.sp_dec)          sp_env <= sp_env - 8'd1;
      else if (bus.sp_inc)          sp_env <= sp_env + 8'd1;
      if (bus.mem_we) ram[sp_env - 8'd1] <= bus.mem_wdata;
      if (bus.mem_re) rdata_q <= ram[sp_env];
    end
  end

  typedef enum int {K_WR, K_LD, K_RSP, K_OVF, K_UNF} kind_t;
  typedef struct {
    kind_t      kind;
    logic [7:0] d;
    logic [7:0] pc;
    int         acc;
    int         lat;
  } ev_t;

  ev_t        sb[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         ref_sp;
  logic [7:0] ref_mem [256];
  logic [7:0] last_pc;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expect_ev(input kind_t k, input logic [7:0] d, input logic [7:0] pc,
                           input bit check_pc, input string nm);
    ev_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: unexpected event with data %0h, expected no event (t=%0t)", nm, d, $time);
      return;
    end
    e = sb.pop_front();
    chk({nm, "_kind"}, k, e.kind);
    chk({nm, "_data"}, d, e.d);
    if (check_pc) chk({nm, "_pc"}, pc, e.pc);
    chk({nm, "_latency"}, cyc - e.acc + 1, e.lat);
  endtask

  // Monitor: every observed output event is matched against the scoreboard.
  initial begin
    logic ok;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.mem_we) expect_ev(K_WR, bus.mem_wdata, 8'h00, 1'b0, "mem_write");
        if (bus.sp_inc && bus.sp_dec) expect_ev(K_LD, bus.sp_load_val, 8'h00, 1'b0, "ldsp");
        if (bus.rsp_valid) expect_ev(K_RSP, bus.rsp_data, bus.rsp_pc, 1'b1, "rsp");
        if (bus.ovf_err) expect_ev(K_OVF, 8'h00, 8'h00, 1'b0, "ovf_err");
        if (bus.unf_err) expect_ev(K_UNF, 8'h00, 8'h00, 1'b0, "unf_err");
        if (!bus.mem_we) chk("wdata_idle", bus.mem_wdata, 0);
        if (!(bus.sp_inc && bus.sp_dec)) chk("load_val_idle", bus.sp_load_val, 0);
        ok = (bus.sp_inc && bus.sp_dec) ? (!bus.mem_we && !bus.mem_re)
             : ((bus.sp_dec == bus.mem_we) && (bus.sp_inc == bus.mem_re));
        chk("strobe_pairing", ok, 1);
      end
    end
  end

  function automatic ev_t mk(input kind_t k, input logic [7:0] d, input logic [7:0] pc,
                             input int acc, input int lat);
    ev_t e;
    e.kind = k; e.d = d; e.pc = pc; e.acc = acc; e.lat = lat;
    return e;
  endfunction

  task automatic do_op(input logic [2:0] op, input logic [7:0] d, input logic [7:0] pc,
                       input logic [7:0] fl);
    int n = 0;
    int dep, acc;
    logic [7:0] rd, rp;
    @(negedge clk);
    while (!bus.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: req_ready 0 expected 1 (t=%0t)", $time);
      return;
    end
    dep = 255 - ref_sp;
    chk("depth", bus.depth, dep);
    acc = cyc + 1;
    case (op)
      OP_PUSH: begin
        if (dep == 255) sb.push_back(mk(K_OVF, 8'h00, 8'h00, acc, 1));
        else begin
          ref_sp--;
          ref_mem[ref_sp] = d;
          sb.push_back(mk(K_WR, d, 8'h00, acc, 1));
        end
      end
      OP_POP: begin
        if (dep == 0) sb.push_back(mk(K_UNF, 8'h00, 8'h00, acc, 1));
        else begin
          rd = ref_mem[ref_sp];
          ref_sp++;
          sb.push_back(mk(K_RSP, rd, last_pc, acc, 3));
        end
      end
      OP_CALL: begin
        if (dep > 253) sb.push_back(mk(K_OVF, 8'h00, 8'h00, acc, 1));
        else begin
          ref_sp--;
          ref_mem[ref_sp] = pc;
          sb.push_back(mk(K_WR, pc, 8'h00, acc, 1));
          ref_sp--;
          ref_mem[ref_sp] = fl;
          sb.push_back(mk(K_WR, fl, 8'h00, acc, 2));
        end
      end
      OP_RET: begin
        if (dep < 2) sb.push_back(mk(K_UNF, 8'h00, 8'h00, acc, 1));
        else begin
          rd = ref_mem[ref_sp];
          ref_sp++;
          rp = ref_mem[ref_sp];
          ref_sp++;
          last_pc = rp;
          sb.push_back(mk(K_RSP, rd, rp, acc, 4));
        end
      end
      OP_LDSP: begin
        ref_sp = int'(d);
        sb.push_back(mk(K_LD, d, 8'h00, acc, 1));
      end
      default: ;
    endcase
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_data  = d;
    bus.req_pc    = pc;
    bus.req_flags = fl;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d events outstanding, expected 0", sb.size());
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    logic [2:0] op;
    logic [7:0] d;
    bus.req_valid = 1'b0;
    bus.req_op    = OP_NOP;
    bus.req_data  = 8'h00;
    bus.req_pc    = 8'h00;
    bus.req_flags = 8'h00;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i) ^ 8'h5A;
    ref_sp  = 255;
    last_pc = 8'h00;

    repeat (3) @(negedge clk);
    chk("rst_ready", bus.req_ready, 1);
    chk("rst_depth", bus.depth, 0);
    chk("rst_strobes", {bus.sp_inc, bus.sp_dec, bus.mem_we, bus.mem_re}, 0);
    chk("rst_pulses", {bus.rsp_valid, bus.ovf_err, bus.unf_err}, 0);
    chk("rst_rsp_data", bus.rsp_data, 0);
    chk("rst_rsp_pc", bus.rsp_pc, 0);
    rst_n = 1'b1;

    do_op(OP_PUSH, 8'hA5, 8'h00, 8'h00);
    @(negedge clk);
    chk("push_busy_ready", bus.req_ready, 0);
    chk("push_sp_dec", bus.sp_dec, 1);
    @(negedge clk);
    chk("push_ready_back", bus.req_ready, 1);
    chk("push_depth_1", bus.depth, 1);
    do_op(OP_POP, 8'h00, 8'h00, 8'h00);

    do_op(OP_PUSH, 8'h11, 8'h00, 8'h00);
    do_op(OP_PUSH, 8'h22, 8'h00, 8'h00);
    do_op(OP_POP, 8'h00, 8'h00, 8'h00);
    do_op(OP_POP, 8'h00, 8'h00, 8'h00);
    do_op(OP_CALL, 8'h00, 8'h40, 8'h05);
    do_op(OP_RET, 8'h00, 8'h00, 8'h00);
    do_op(OP_POP, 8'h00, 8'h00, 8'h00);
    do_op(OP_PUSH, 8'h33, 8'h00, 8'h00);
    do_op(OP_RET, 8'h00, 8'h00, 8'h00);
    do_op(OP_POP, 8'h00, 8'h00, 8'h00);
    do_op(3'd6, 8'h12, 8'h34, 8'h56);
    do_op(3'd7, 8'h12, 8'h34, 8'h56);
    do_op(OP_NOP, 8'h12, 8'h34, 8'h56);
    do_op(OP_LDSP, 8'h00, 8'h00, 8'h00);
    do_op(OP_PUSH, 8'h77, 8'h00, 8'h00);
    do_op(OP_CALL, 8'h00, 8'h12, 8'h34);
    do_op(OP_LDSP, 8'h01, 8'h00, 8'h00);
    do_op(OP_CALL, 8'h00, 8'h12, 8'h34);
    do_op(OP_PUSH, 8'h78, 8'h00, 8'h00);
    do_op(OP_LDSP, 8'hF0, 8'h00, 8'h00);
    drain();
    chk("ldsp_f0_depth", bus.depth, 15);
    do_op(OP_LDSP, 8'hFF, 8'h00, 8'h00);

    for (int k = 0; k < 400; k++) begin
      op = 3'($urandom_range(0, 7));
      if (op == OP_LDSP && $urandom_range(0, 3) != 0) op = OP_PUSH;
      d = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
      do_op(op, d, 8'($urandom), 8'($urandom));
    end
    drain();

    // Asynchronous reset in the middle of a CALL.
    do_op(OP_CALL, 8'h00, 8'h77, 8'h99);
    @(posedge clk);
    #1;
    chk("call_fl_we", bus.mem_we, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_we", bus.mem_we, 0);
    chk("abort_sp_dec", bus.sp_dec, 0);
    chk("abort_ready", bus.req_ready, 1);
    chk("abort_depth", bus.depth, 0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    ref_sp  = 255;
    last_pc = 8'h00;
    do_op(OP_LDSP, 8'hFF, 8'h00, 8'h00);
    do_op(OP_PUSH, 8'hC3, 8'h00, 8'h00);
    do_op(OP_POP, 8'h00, 8'h00, 8'h00);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
